mips_mc_ctrl: RTL and testbench
===============================

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 Parameter ILL_SKIP, default 1: when 1, an illegal instruction advances the PC; when 0, it halts in IDLE.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 run  input  1  level enable; while high the controller keeps fetching.
REQ-006 inst_ack  input  1  instruction memory has the word; Inst_code is valid this cycle.
REQ-007 op_code  input  6  decoded Inst_code[31:26] from the field decoder.
REQ-008 func  input  6  decoded Inst_code[5:0] from the field decoder.
REQ-009 inst_req  output  1  fetch request to instruction memory.
REQ-010 ir_we  output  1  load the instruction register.
REQ-011 pc_we  output  1  PC <= PC+4.
REQ-012 rf_we  output  1  register-file write of rd_addr.
REQ-013 alu_op  output  4  ALU operation select.
REQ-014 alu_shamt  output  1  ALU B operand comes from shamt instead of rt.
REQ-015 busy  output  1  state is not IDLE.
REQ-016 done  output  1  one-cycle pulse when an instruction retires.
REQ-017 illegal  output  1  one-cycle pulse when an unsupported instruction retires.
REQ-018 instr_cnt  output  CNT_W  count of retired legal instructions.

Function
REQ-019 Five states SHALL be used: IDLE, FETCH, DECODE, EXEC and WB.
REQ-020 IDLE->FETCH when run=1; otherwise hold IDLE.
REQ-021 FETCH: inst_req=1; hold until inst_ack=1; in the ack cycle ir_we=1 and next state is DECODE; any number of wait cycles is legal.
REQ-022 DECODE, one cycle: op_code/func are sampled at the end of the cycle into a registered alu_op/alu_shamt/legal flag.
REQ-023 Legal means op_code=6'h00 and func in {20 add, 21 addu, 22 sub, 23 subu, 24 and, 25 or, 26 xor, 27 nor, 2A slt}, plus {00 sll, 02 srl} under MIPS_CTRL_SHIFT_EN.
REQ-024 alu_op encoding: ADD=0 (add, addu), SUB=1 (sub, subu), AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLL=7, SRL=8; illegal yields 0.
REQ-025 EXEC, one cycle: the registered alu_op/alu_shamt are driven; they hold through WB and are 0 in every other state.
REQ-026 WB, one cycle: pc_we=1 and done=1.
- Legal instruction: rf_we=1 and instr_cnt increments.
- Illegal instruction: rf_we=0, illegal=1, instr_cnt unchanged.
REQ-027 Latency: inst_ack in cycle T gives rf_we/done in cycle T+3; with zero-wait memory, one instruction retires per 4 cycles.
REQ-028 WB exit: FETCH if run=1, else IDLE.
REQ-029 When illegal and ILL_SKIP=0, WB asserts pc_we=0 and goes to IDLE regardless of run.
REQ-030 run is ignored mid-instruction: deasserting it outside WB/IDLE does not abort the instruction.
REQ-031 instr_cnt wraps from all-ones to 0 silently.
REQ-032 inst_ack outside FETCH SHALL be ignored.

Reset
REQ-033 rst=1 immediately forces IDLE, including mid-instruction, with no writeback.
REQ-034 On reset every output is 0, instr_cnt is 0 and the registered decode fields are 0.
REQ-035 The first FETCH can occur no earlier than the first rising edge after rst falls with run=1.

Configuration
REQ-036 Macro MIPS_CTRL_SHIFT_EN.
- Defined: sll/srl are legal, alu_shamt=1 for them, and alu_op is 7 or 8.
- Undefined: func 00/02 are illegal and alu_shamt is tied to 0.

Structure
REQ-037 Package mips_pkg SHALL hold the state enum, ALU_* op codes, FUNC_* codes and OP_RTYPE.
REQ-038 One combinational sub-module mips_alu_dec (op_code, func -> alu_op, alu_shamt, legal) SHALL be used; the FSM and counter stay in mips_mc_ctrl.

Verification
REQ-039 Reset then run=1 with zero-wait ack and func=20 (add) -> inst_req in cycle 1, rf_we/done in cycle 4, alu_op=0, instr_cnt=1.
REQ-040 inst_ack delayed 3 cycles with func=2A -> inst_req held for 4 cycles, alu_op=6, rf_we exactly 3 cycles after ack.
REQ-041 op_code=6'h23 with ILL_SKIP=1 -> illegal=1, rf_we=0, pc_we=1, instr_cnt unchanged, next FETCH issued; with ILL_SKIP=0 -> pc_we=0, IDLE.
REQ-042 func=00 (sll) -> alu_op=7, alu_shamt=1 with the macro defined; illegal=1 with it undefined.
REQ-043 rst pulsed during EXEC -> outputs 0 in the same cycle, no rf_we, instr_cnt=0.
REQ-044 CNT_W=4 with 16 back-to-back adds -> instr_cnt wraps to 0; run dropped mid-EXEC -> that instruction retires, then IDLE with busy=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and encodings for the multi-cycle MIPS R-type controller.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;

  localparam logic [5:0] FUNC_SLL  = 6'h00;
  localparam logic [5:0] FUNC_SRL  = 6'h02;
  localparam logic [5:0] FUNC_ADD  = 6'h20;
  localparam logic [5:0] FUNC_ADDU = 6'h21;
  localparam logic [5:0] FUNC_SUB  = 6'h22;
  localparam logic [5:0] FUNC_SUBU = 6'h23;
  localparam logic [5:0] FUNC_AND  = 6'h24;
  localparam logic [5:0] FUNC_OR   = 6'h25;
  localparam logic [5:0] FUNC_XOR  = 6'h26;
  localparam logic [5:0] FUNC_NOR  = 6'h27;
  localparam logic [5:0] FUNC_SLT  = 6'h2A;

endpackage

// File: rtl/mips_alu_dec.sv
// R-type opcode/func decoder: purely combinational, no backpressure.
// Shift ops (sll/srl) are legal only when MIPS_CTRL_SHIFT_EN is defined.
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] op_code,
  input  logic [5:0] func,
  output logic [3:0] alu_op,
  output logic       alu_shamt,
  output logic       legal
);

  always_comb begin
    alu_op    = ALU_ADD;
    alu_shamt = 1'b0;
    legal     = 1'b0;
    if (op_code == OP_RTYPE) begin
      legal = 1'b1;
      case (func)
        FUNC_ADD, FUNC_ADDU: alu_op = ALU_ADD;
        FUNC_SUB, FUNC_SUBU: alu_op = ALU_SUB;
        FUNC_AND:            alu_op = ALU_AND;
        FUNC_OR:             alu_op = ALU_OR;
        FUNC_XOR:            alu_op = ALU_XOR;
        FUNC_NOR:            alu_op = ALU_NOR;
        FUNC_SLT:            alu_op = ALU_SLT;
`ifdef MIPS_CTRL_SHIFT_EN
        FUNC_SLL: begin
          alu_op    = ALU_SLL;
          alu_shamt = 1'b1;
        end
        FUNC_SRL: begin
          alu_op    = ALU_SRL;
          alu_shamt = 1'b1;
        end
`endif
        default:             legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle IDLE/FETCH/DECODE/EXEC/WB controller; ack in cycle T retires in T+3, FETCH waits on inst_ack.
// Optional sll/srl support via MIPS_CTRL_SHIFT_EN (decoded in mips_alu_dec).
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int ILL_SKIP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             inst_ack,
  input  logic [5:0]       op_code,
  input  logic [5:0]       func,
  output logic             inst_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic [3:0]       alu_op,
  output logic             alu_shamt,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t     state_q, state_d;
  logic [3:0] dec_op;
  logic       dec_shamt, dec_legal;
  logic [3:0] alu_op_q;
  logic       alu_shamt_q, legal_q;

  mips_alu_dec u_alu_dec (
    .op_code   (op_code),
    .func      (func),
    .alu_op    (dec_op),
    .alu_shamt (dec_shamt),
    .legal     (dec_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Decode fields are captured once, at the end of DECODE, and held through WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op_q    <= ALU_ADD;
      alu_shamt_q <= 1'b0;
      legal_q     <= 1'b0;
    end else if (state_q == ST_DECODE) begin
      alu_op_q    <= dec_op;
      alu_shamt_q <= dec_shamt;
      legal_q     <= dec_legal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      instr_cnt <= '0;
    else if (state_q == ST_WB && legal_q)
      instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    state_d   = state_q;
    inst_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    alu_op    = 4'd0;
    alu_shamt = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        inst_req = 1'b1;
        if (inst_ack) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        alu_op    = alu_op_q;
        alu_shamt = alu_shamt_q;
        state_d   = ST_WB;
      end
      ST_WB: begin
        alu_op    = alu_op_q;
        alu_shamt = alu_shamt_q;
        done      = 1'b1;
        rf_we     = legal_q;
        illegal   = !legal_q;
        // Without skip, an illegal instruction parks the core and leaves the PC on it.
        if (!legal_q && ILL_SKIP == 0) begin
          state_d = ST_IDLE;
        end else begin
          pc_we   = 1'b1;
          state_d = run ? ST_FETCH : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench: instance a (CNT_W=16, ILL_SKIP=1) and instance b (CNT_W=4, ILL_SKIP=0) share stimulus.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b1;
  logic       inst_ack = 1'b0;
  logic [5:0] op_code = 6'h00;
  logic [5:0] func = 6'h00;

  logic        inst_req_a, ir_we_a, pc_we_a, rf_we_a, alu_shamt_a, busy_a, done_a, illegal_a;
  logic [3:0]  alu_op_a;
  logic [15:0] cnt_a;
  logic        inst_req_b, ir_we_b, pc_we_b, rf_we_b, alu_shamt_b, busy_b, done_b, illegal_b;
  logic [3:0]  alu_op_b;
  logic [3:0]  cnt_b;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_a = '0;
  logic [3:0]  exp_b = '0;

  logic [5:0] fv [9] = '{6'h20, 6'h2A, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h21};
  logic [3:0] ov [9] = '{4'd0,  4'd6,  4'd1,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd0};
  int         wv [9] = '{0, 3, 0, 1, 0, 0, 2, 0, 1};

  always #5 clk = ~clk;

  mips_mc_ctrl #(.CNT_W(16), .ILL_SKIP(1)) dut_a (
    .clk(clk), .rst(rst), .run(run), .inst_ack(inst_ack), .op_code(op_code), .func(func),
    .inst_req(inst_req_a), .ir_we(ir_we_a), .pc_we(pc_we_a), .rf_we(rf_we_a),
    .alu_op(alu_op_a), .alu_shamt(alu_shamt_a), .busy(busy_a), .done(done_a),
    .illegal(illegal_a), .instr_cnt(cnt_a)
  );

  mips_mc_ctrl #(.CNT_W(4), .ILL_SKIP(0)) dut_b (
    .clk(clk), .rst(rst), .run(run), .inst_ack(inst_ack), .op_code(op_code), .func(func),
    .inst_req(inst_req_b), .ir_we(ir_we_b), .pc_we(pc_we_b), .rf_we(rf_we_b),
    .alu_op(alu_op_b), .alu_shamt(alu_shamt_b), .busy(busy_b), .done(done_b),
    .illegal(illegal_b), .instr_cnt(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one instruction starting in a FETCH cycle; ends inside its WB cycle.
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int waits,
                          input logic [3:0] e_op, input logic e_sh, input logic e_legal,
                          input logic drop_run);
    op_code = op;
    func    = fn;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk); inst_ack = 1'b0; #1;
      chk("wait_req", inst_req_a, 1'b1);
      chk("wait_ir_we", ir_we_a, 1'b0);
    end
    @(negedge clk); inst_ack = 1'b1; #1;
    chk("ack_req", inst_req_a, 1'b1);
    chk("ack_ir_we", ir_we_a, 1'b1);
    chk("ack_ir_we_b", ir_we_b, 1'b1);
    @(negedge clk); #1;                // DECODE; the held ack must be ignored
    chk("dec_req", inst_req_a, 1'b0);
    chk("dec_ir_we", ir_we_a, 1'b0);
    chk("dec_alu_op", alu_op_a, 4'd0);
    @(negedge clk); inst_ack = 1'b0; op_code = 6'h3F; func = 6'h3F;
    if (drop_run) run = 1'b0;
    #1;                                // EXEC with garbage on the decoder inputs
    chk("exec_alu_op", alu_op_a, e_op);
    chk("exec_shamt", alu_shamt_a, e_sh);
    chk("exec_rf_we", rf_we_a, 1'b0);
    chk("exec_done", done_a, 1'b0);
    @(negedge clk); #1;                // WB
    chk("wb_alu_op", alu_op_a, e_op);
    chk("wb_done", done_a, 1'b1);
    chk("wb_rf_we", rf_we_a, e_legal);
    chk("wb_illegal", illegal_a, !e_legal);
    chk("wb_pc_we", pc_we_a, 1'b1);
    chk("wb_rf_we_b", rf_we_b, e_legal);
    chk("wb_pc_we_b", pc_we_b, e_legal);
    chk("wb_illegal_b", illegal_b, !e_legal);
  endtask

  task automatic chk_cnt(input string tag);
    @(posedge clk); #1;
    chk(tag, cnt_a, exp_a);
    chk(tag, cnt_b, exp_b);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; #1;
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_busy_b", busy_b, 1'b0);
    chk("rst_cnt_a", cnt_a, 16'd0);
    @(negedge clk); rst = 1'b0; run = 1'b1;
    exp_a = '0;
    exp_b = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic sll_legal;
    #1;
    chk("rst0_inst_req", inst_req_a, 1'b0);
    chk("rst0_pc_we", pc_we_a, 1'b0);
    chk("rst0_rf_we", rf_we_a, 1'b0);
    chk("rst0_alu_op", alu_op_a, 4'd0);
    chk("rst0_done", done_a, 1'b0);
    chk("rst0_cnt", cnt_a, 16'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("rst_hold_busy", busy_a, 1'b0);
      chk("rst_hold_req", inst_req_a, 1'b0);
    end
    @(negedge clk); rst = 1'b0;        // first FETCH at the next rising edge

    for (int i = 0; i < 9; i++) begin
      do_instr(6'h00, fv[i], wv[i], ov[i], 1'b0, 1'b1, 1'b0);
      exp_a++; exp_b++;
      chk_cnt("cnt_mix");
    end

    for (int i = 0; i < 16; i++) begin
      do_instr(6'h00, 6'h20, 0, 4'd0, 1'b0, 1'b1, 1'b0);
      exp_a++; exp_b++;
      chk_cnt("cnt_adds");
      if (exp_a == 16'd16) chk("cnt_b_wrap", cnt_b, 4'd0);
    end

    // Reset in the middle of EXEC of a sub.
    op_code = 6'h00; func = 6'h22;
    @(negedge clk); inst_ack = 1'b1;
    @(negedge clk); inst_ack = 1'b0;
    @(negedge clk); #1;
    chk("pre_rst_alu_op", alu_op_a, 4'd1);
    rst = 1'b1; #1;
    chk("mid_rst_busy", busy_a, 1'b0);
    chk("mid_rst_alu_op", alu_op_a, 4'd0);
    chk("mid_rst_cnt_a", cnt_a, 16'd0);
    chk("mid_rst_cnt_b", cnt_b, 4'd0);
    @(negedge clk); #1;
    chk("mid_rst_rf_we", rf_we_a, 1'b0);
    chk("mid_rst_done", done_a, 1'b0);
    chk("mid_rst_busy2", busy_a, 1'b0);
    rst = 1'b0;
    exp_a = '0; exp_b = '0;

    // run dropped during EXEC: instruction still retires, then IDLE.
    do_instr(6'h00, 6'h20, 0, 4'd0, 1'b0, 1'b1, 1'b1);
    exp_a++; exp_b++;
    chk_cnt("cnt_drop");
    @(negedge clk); #1;
    chk("drop_busy_a", busy_a, 1'b0);
    chk("drop_busy_b", busy_b, 1'b0);
    chk("drop_req", inst_req_a, 1'b0);
    run = 1'b1;

`ifdef MIPS_CTRL_SHIFT_EN
    sll_legal = 1'b1;
    do_instr(6'h00, 6'h00, 0, 4'd7, 1'b1, 1'b1, 1'b0);
`else
    sll_legal = 1'b0;
    do_instr(6'h00, 6'h00, 0, 4'd0, 1'b0, 1'b0, 1'b0);
`endif
    if (sll_legal) begin
      exp_a++; exp_b++;
    end
    chk_cnt("cnt_sll");
    do_reset();

    // Non-R-type opcode: skip on a, park on b.
    do_instr(6'h23, 6'h20, 0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("ill_cnt_a", cnt_a, exp_a);
    chk("ill_next_fetch_a", inst_req_a, 1'b1);
    chk("ill_idle_b", busy_b, 1'b0);
    chk("ill_no_req_b", inst_req_b, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
